// File: rtl/tt_board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tt_board_pkg                                                     |
// | Purpose : Shared types and helpers for the ULX3S TinyTapeout board harness.|
// |           Holds the Tiny VGA PMOD pin record, the uo_out -> VGA unpacking  |
// |           function and the GPIO pair indices the PMOD lands on.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tt_board_pkg;

  // Two bits per colour: [1] is the MSB pin (R1/G1/B1), [0] the LSB pin (R0/G0/B0).
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } vga_pins_t;

  // GPIO pair indices of the PMOD. gn carries R1/G1/B1/VS, gp carries R0/G0/B0/HS.
  localparam int GPIO_IDX_SYNC = 21;
  localparam int GPIO_IDX_B    = 22;
  localparam int GPIO_IDX_G    = 23;
  localparam int GPIO_IDX_R    = 24;

  // Tiny VGA order on uo_out: {HS, B0, G0, R0, VS, B1, G1, R1} from bit 7 down to bit 0.
  function automatic vga_pins_t uo_to_vga(input logic [7:0] uo);
    vga_pins_t v;
    v.r  = {uo[0], uo[4]};
    v.g  = {uo[1], uo[5]};
    v.b  = {uo[2], uo[6]};
    v.vs = uo[3];
    v.hs = uo[7];
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tt_debounce                                                      |
// | Purpose : One button channel: 2-FF synchroniser followed by a stability    |
// |           counter. The output flips only after the synchronised input has  |
// |           differed from it for DEBOUNCE_CYC consecutive cycles.            |
// | Ports   : video_clk  in  clock                                             |
// |           reset_n    in  asynchronous active-low reset                     |
// |           btn_raw    in  raw asynchronous button level                     |
// |           btn_deb    out debounced level                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tt_debounce #(
  parameter int DEBOUNCE_CYC = 400000
) (
  input  logic video_clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_deb
);

  localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q,   deb_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    if (sync2_q == deb_q) begin
      // Any agreement restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_deb = deb_q;

endmodule
`default_nettype wire

// File: rtl/tt_board_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tt_board_harness                                                 |
// | Purpose : Board-side harness between the PLL and a TinyTapeout user design |
// |           on ULX3S: lock-qualified design reset, debounced buttons onto    |
// |           ui_in, heartbeat/frame-count LEDs and the Tiny VGA PMOD pinout.  |
// | Ports   : video_clk     in   pixel clock                                   |
// |           reset_n       in   board reset, async active-low                 |
// |           pll_locked    in   PLL lock (asynchronous)                       |
// |           btn           in   raw buttons [N_BTN-1:1]                       |
// |           uo_out        in   user outputs, Tiny VGA order                  |
// |           uio_out/oe    in   user bidir outputs / enables                  |
// |           design_rst_n  out  user design reset, active-low                 |
// |           ena           out  user design enable                            |
// |           ui_in         out  debounced buttons, zero-extended              |
// |           uio_in        out  bidir loopback                                |
// |           led           out  {frame_cnt, ~hb, hb}                          |
// |           gp, gn        out  GPIO pairs carrying the VGA PMOD              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tt_board_harness
  import tt_board_pkg::*;
#(
  parameter int N_BTN        = 7,
  parameter int DEBOUNCE_CYC = 400000,
  parameter int RST_HOLD     = 16,
  parameter int HB_BITS      = 24,
  parameter bit VSYNC_ACT_LO = 1'b1,
  parameter bit PIN_REG      = 1'b1
) (
  input  logic             video_clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic [N_BTN-1:1] btn,
  input  logic [7:0]       uo_out,
  input  logic [7:0]       uio_out,
  input  logic [7:0]       uio_oe,
  output logic             design_rst_n,
  output logic             ena,
  output logic [7:0]       ui_in,
  output logic [7:0]       uio_in,
  output logic [7:0]       led,
  output logic [27:0]      gp,
  output logic [27:0]      gn
);

  localparam int                HOLD_W   = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);

  // ---------------------------------------------------------------- reset gen
  logic              lock_s1_q,      lock_s1_d;
  logic              lock_s2_q,      lock_s2_d;
  logic [HOLD_W-1:0] hold_cnt_q,     hold_cnt_d;
  logic              design_rst_n_q, design_rst_n_d;

  always_comb begin
    lock_s1_d  = pll_locked;
    lock_s2_d  = lock_s1_q;
    hold_cnt_d = hold_cnt_q;
    if (!lock_s2_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    // Release lands on the same edge the counter saturates.
    design_rst_n_d = lock_s2_q && (hold_cnt_d == HOLD_MAX);
  end

  // ---------------------------------------------------------------- heartbeat / frames
  logic [HB_BITS-1:0] hb_q,        hb_d;
  logic               vs_q,        vs_d;
  logic               vs_prev_q,   vs_prev_d;
  logic [5:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]         led_q,       led_d;
  logic               frame_edge;

  always_comb begin
    hb_d       = hb_q + HB_BITS'(1);
    vs_d       = uo_out[3];
    vs_prev_d  = vs_q;
    frame_edge = VSYNC_ACT_LO ? (vs_prev_q & ~vs_q) : (~vs_prev_q & vs_q);
    if (!design_rst_n_q) begin
      frame_cnt_d = '0;
    end else begin
      frame_cnt_d = frame_cnt_q + 6'(frame_edge);
    end
    // LEDs are registered from next-state values so they read 0 in reset
    // yet stay aligned with the counters they mirror.
    led_d = {frame_cnt_d, ~hb_d[HB_BITS-1], hb_d[HB_BITS-1]};
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1_q      <= 1'b0;
      lock_s2_q      <= 1'b0;
      hold_cnt_q     <= '0;
      design_rst_n_q <= 1'b0;
      hb_q           <= '0;
      vs_q           <= 1'b0;
      vs_prev_q      <= 1'b0;
      frame_cnt_q    <= '0;
      led_q          <= '0;
    end else begin
      lock_s1_q      <= lock_s1_d;
      lock_s2_q      <= lock_s2_d;
      hold_cnt_q     <= hold_cnt_d;
      design_rst_n_q <= design_rst_n_d;
      hb_q           <= hb_d;
      vs_q           <= vs_d;
      vs_prev_q      <= vs_prev_d;
      frame_cnt_q    <= frame_cnt_d;
      led_q          <= led_d;
    end
  end

  assign design_rst_n = design_rst_n_q;
  assign ena          = design_rst_n_q;
  assign led          = led_q;

  // ---------------------------------------------------------------- buttons
  logic [N_BTN-1:1] deb;

  for (genvar i = 1; i < N_BTN; i++) begin : g_btn
    tt_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .video_clk (video_clk),
      .reset_n   (reset_n),
      .btn_raw   (btn[i]),
      .btn_deb   (deb[i])
    );
  end

  always_comb begin
    ui_in = '0;
    for (int k = 0; k < N_BTN - 1; k++) begin
      ui_in[k] = deb[k+1];
    end
  end

  assign uio_in = uio_out & uio_oe;

  // ---------------------------------------------------------------- VGA pins
  vga_pins_t vga_now;
  vga_pins_t pins_out;

  assign vga_now = uo_to_vga(uo_out);

  if (PIN_REG) begin : g_pin_reg
    // One register stage for all eight pins keeps HS/VS aligned with colour.
    vga_pins_t pins_q, pins_d;

    always_comb begin
      pins_d = design_rst_n_d ? vga_now : '0;
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
      if (!reset_n) begin
        pins_q <= '0;
      end else begin
        pins_q <= pins_d;
      end
    end

    assign pins_out = pins_q;
  end else begin : g_pin_comb
    assign pins_out = design_rst_n_q ? vga_now : '0;
  end

  always_comb begin
    gp = '0;
    gn = '0;
    gn[GPIO_IDX_SYNC] = pins_out.vs;
    gp[GPIO_IDX_SYNC] = pins_out.hs;
    gn[GPIO_IDX_B]    = pins_out.b[1];
    gp[GPIO_IDX_B]    = pins_out.b[0];
    gn[GPIO_IDX_G]    = pins_out.g[1];
    gp[GPIO_IDX_G]    = pins_out.g[0];
    gn[GPIO_IDX_R]    = pins_out.r[1];
    gp[GPIO_IDX_R]    = pins_out.r[0];
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_board_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tt_board_harness                                              |
// | Purpose : Self-checking bench for tt_board_harness with a small behavioural|
// |           model compared every cycle plus hand-computed directed checks.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tt_board_harness;

  localparam int N_BTN = 7;
  localparam int DEB   = 8;
  localparam int HOLD  = 4;
  localparam int HBB   = 4;

  logic        video_clk  = 1'b0;
  logic        reset_n    = 1'b0;
  logic        pll_locked = 1'b0;
  logic [6:1]  btn        = '0;
  logic [7:0]  uo_out     = '0;
  logic [7:0]  uio_out    = '0;
  logic [7:0]  uio_oe     = '0;
  logic        design_rst_n;
  logic        ena;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic [7:0]  led;
  logic [27:0] gp;
  logic [27:0] gn;

  tt_board_harness #(
    .N_BTN        (N_BTN),
    .DEBOUNCE_CYC (DEB),
    .RST_HOLD     (HOLD),
    .HB_BITS      (HBB),
    .VSYNC_ACT_LO (1'b1),
    .PIN_REG      (1'b1)
  ) dut (
    .video_clk    (video_clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .btn          (btn),
    .uo_out       (uo_out),
    .uio_out      (uio_out),
    .uio_oe       (uio_oe),
    .design_rst_n (design_rst_n),
    .ena          (ena),
    .ui_in        (ui_in),
    .uio_in       (uio_in),
    .led          (led),
    .gp           (gp),
    .gn           (gn)
  );

  always #5 video_clk = ~video_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected PMOD pins for a uo_out word, straight from the pin table.
  function automatic logic [27:0] exp_gn(input logic [7:0] u);
    logic [27:0] r;
    r = '0;
    r[24] = u[0]; r[23] = u[1]; r[22] = u[2]; r[21] = u[3];
    return r;
  endfunction

  function automatic logic [27:0] exp_gp(input logic [7:0] u);
    logic [27:0] r;
    r = '0;
    r[24] = u[4]; r[23] = u[5]; r[22] = u[6]; r[21] = u[7];
    return r;
  endfunction

  // ---------------------------------------------------------------- model
  // Inputs seen at the last two clock edges, and derived state.
  bit       m_p1, m_p2;
  int       m_run;
  bit       m_rst;
  int       m_edges;
  bit       m_vs1, m_vs2;
  int       m_frame;
  bit [5:0] m_b1, m_b2, m_deb;
  int       m_drun [6];

  always @(negedge video_clk) begin
    if (!reset_n) begin
      m_p1 = 0; m_p2 = 0; m_run = 0; m_rst = 0; m_edges = 0;
      m_vs1 = 0; m_vs2 = 0; m_frame = 0;
      m_b1 = '0; m_b2 = '0; m_deb = '0;
      for (int c = 0; c < 6; c++) m_drun[c] = 0;
      chk("mon_reset_rst_n", {31'd0, design_rst_n}, 32'd0);
      chk("mon_reset_outs", {ena, ui_in, led, 15'd0}, 32'd0);
      chk("mon_reset_pins", {4'd0, gp | gn}, 32'd0);
    end else begin
      // Inputs are stable from just after a negedge through the next negedge,
      // so their present values are what the last rising edge sampled.
      bit s;
      bit old_rst;
      bit fall;
      bit hb0;
      s       = m_p2;
      m_p2    = m_p1;
      m_p1    = pll_locked;
      old_rst = m_rst;
      m_run   = s ? ((m_run < HOLD) ? m_run + 1 : HOLD) : 0;
      m_rst   = (m_run >= HOLD);

      fall  = m_vs2 && !m_vs1;
      m_vs2 = m_vs1;
      m_vs1 = uo_out[3];
      m_frame = old_rst ? (m_frame + int'(fall)) % 64 : 0;

      for (int c = 0; c < 6; c++) begin
        if (m_b2[c] != m_deb[c]) begin
          m_drun[c]++;
          if (m_drun[c] == DEB) begin
            m_deb[c]  = ~m_deb[c];
            m_drun[c] = 0;
          end
        end else begin
          m_drun[c] = 0;
        end
      end
      m_b2 = m_b1;
      m_b1 = btn;

      m_edges++;
      hb0 = (m_edges % (1 << HBB)) >= (1 << (HBB - 1));

      chk("mon_design_rst_n", {31'd0, design_rst_n}, {31'd0, m_rst});
      chk("mon_ena",          {31'd0, ena},          {31'd0, m_rst});
      chk("mon_ui_in",        {24'd0, ui_in},        {26'd0, m_deb});
      chk("mon_uio_in",       {24'd0, uio_in},       {24'd0, uio_out & uio_oe});
      chk("mon_led",          {24'd0, led},          {24'd0, 6'(m_frame), !hb0, hb0});
      chk("mon_gn", {4'd0, gn}, m_rst ? {4'd0, exp_gn(uo_out)} : 32'd0);
      chk("mon_gp", {4'd0, gp}, m_rst ? {4'd0, exp_gp(uo_out)} : 32'd0);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(negedge video_clk);
      #1;
    end
  endtask

  initial begin
    int  cnt;
    bit  led0_prev;

    pll_locked = 1'b1;
    step(3);
    chk("reset_design_rst_n", {31'd0, design_rst_n}, 32'd0);
    chk("reset_led",          {24'd0, led},          32'd0);

    // Release: design_rst_n rises 2 sync + 4 hold edges later.
    reset_n = 1'b1;
    cnt = 0;
    while (!design_rst_n && cnt < 20) begin
      step(1);
      cnt++;
    end
    chk("release_latency", cnt, 6);
    chk("release_ena", {31'd0, ena}, 32'd1);

    // One-cycle lock drop: seen 3 edges later, re-release 4 edges after that.
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    cnt = 1;
    while (design_rst_n && cnt < 20) begin
      step(1);
      cnt++;
    end
    chk("lockdrop_latency", cnt, 3);
    cnt = 0;
    while (!design_rst_n && cnt < 20) begin
      step(1);
      cnt++;
    end
    chk("relock_latency", cnt, 4);

    // Bidir loopback.
    uio_out = 8'hFF;
    uio_oe  = 8'h0F;
    #1;
    chk("uio_loopback", {24'd0, uio_in}, 32'h0F);

    // 5-cycle glitch never reaches ui_in.
    btn[1] = 1'b1;
    step(5);
    btn[1] = 1'b0;
    step(15);
    chk("glitch_ignored", {24'd0, ui_in}, 32'd0);

    // Held press: flips 8 cycles after the 2-cycle synchroniser.
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    step(9);
    chk("press_before", {24'd0, ui_in}, 32'h00);
    step(1);
    chk("press_after", {24'd0, ui_in}, 32'h05);
    step(10);
    btn[1] = 1'b0;
    btn[3] = 1'b0;
    step(9);
    chk("release_before", {24'd0, ui_in}, 32'h05);
    step(1);
    chk("release_after", {24'd0, ui_in}, 32'h00);

    // Pin map, one registered edge after the change.
    uo_out = 8'hA5;
    step(1);
    chk("pins_A5_gn", {28'd0, gn[24:21]}, 32'b1010);
    chk("pins_A5_gp", {28'd0, gp[24:21]}, 32'b0101);
    uo_out = 8'h5A;
    step(1);
    chk("pins_5A_gn", {28'd0, gn[24:21]}, 32'b0101);
    chk("pins_5A_gp", {28'd0, gp[24:21]}, 32'b1010);

    // 70 vsync low pulses; button 2 held so ui_in is non-zero at the reset below.
    uo_out = 8'h08;
    btn[2] = 1'b1;
    step(2);
    for (int p = 0; p < 70; p++) begin
      uo_out[3] = 1'b0;
      step(2);
      uo_out[3] = 1'b1;
      step(2);
    end
    step(3);
    chk("frame_count_70", {26'd0, led[7:2]}, 32'd6);
    chk("ui_in_btn2", {24'd0, ui_in}, 32'h02);

    led0_prev = led[0];
    step(8);
    chk("heartbeat_toggle", {31'd0, led[0]}, {31'd0, ~led0_prev});

    // Asynchronous reset in the middle of a cycle.
    reset_n = 1'b0;
    #1;
    chk("async_rst_n",  {31'd0, design_rst_n}, 32'd0);
    chk("async_outs",   {ena, ui_in, led, 15'd0}, 32'd0);
    chk("async_gp",     {4'd0, gp}, 32'd0);
    chk("async_gn",     {4'd0, gn}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
